// File: rtl/ex_hazard_ctrl_pkg.sv
// Shared types for the EX-stage hazard/forwarding controller: forward-select
// codes, FSM state encodings and the in-flight scoreboard entry.
package ex_hazard_ctrl_pkg;

  localparam int SB_REG_W = 5;

  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  typedef enum logic [1:0] {
    ST_RUN        = 2'd0,
    ST_LOAD_STALL = 2'd1,
    ST_FLUSH      = 2'd2,
    ST_FROZEN     = 2'd3
  } hz_state_e;

  typedef struct packed {
    logic [SB_REG_W-1:0] dest;
    logic                reg_write;
    logic                mem_read;
  } sb_entry_t;

  localparam sb_entry_t SB_BUBBLE = '{dest: '0, reg_write: 1'b0, mem_read: 1'b0};

  // True when the entry will produce a value for register src; $0 never counts.
  function automatic logic src_hits(input sb_entry_t e, input logic [SB_REG_W-1:0] src);
    return e.reg_write && (e.dest == src) && (src != '0);
  endfunction

endpackage

// File: rtl/ex_hazard_ctrl_fwd_sel.sv
// Forward-select compare for one EX operand, evaluated for the instruction
// about to enter EX against the two older in-flight instructions.
module hz_fwd_sel
  import ex_hazard_ctrl_pkg::*;
(
  input  logic [SB_REG_W-1:0] src,
  input  sb_entry_t           ex_entry,
  input  sb_entry_t           mem_entry,
  output logic [1:0]          fwd
);

  // The load/ALU distinction does not matter for operand selection.
  logic unused_mem_read;
  assign unused_mem_read = ex_entry.mem_read ^ mem_entry.mem_read;

  // Current EX occupant will sit in MEM when the consumer reaches EX, hence
  // FWD_MEM; the current MEM occupant will be in WB, hence FWD_WB.
  always_comb begin
    // NOTE: default first so every path assigns fwd and no latch is inferred.
    fwd = FWD_REG;
    if (src_hits(ex_entry, src)) begin
      fwd = FWD_MEM;
    end else if (src_hits(mem_entry, src)) begin
      fwd = FWD_WB;
    end
  end

endmodule

// File: rtl/ex_hazard_ctrl.sv
// EX-stage hazard controller: shadow scoreboard of EX/MEM/WB destinations,
// registered operand forwarding, stall/flush/freeze controls and perf counters.
module ex_hazard_ctrl
  import ex_hazard_ctrl_pkg::*;
#(
  parameter int REG_W = SB_REG_W,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [REG_W-1:0] ID_rs,
  input  logic [REG_W-1:0] ID_rt,
  input  logic [REG_W-1:0] ID_Dest,
  input  logic             ID_RegWrite,
  input  logic             ID_MemRead,
  input  logic             ID_Jump,
  input  logic             EX_Branch_EN,
  input  logic             Mem_Busy,
  output logic [1:0]       ForwardA,
  output logic [1:0]       ForwardB,
  output logic             Stall_IF_ID,
  output logic             Flush_IF_ID,
  output logic             Flush_ID_EX,
  output logic             Freeze,
  output logic [CNT_W-1:0] Stall_Cnt,
  output logic [CNT_W-1:0] Flush_Cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  hz_state_e  state;
  sb_entry_t  sb_ex, sb_mem, sb_wb;
  logic [1:0] fwd_a_next, fwd_b_next;
  logic       active, load_use, branch_flush, jump_flush, bubble;

  // The regfile is write-first, so the WB entry never needs a forward; it is
  // kept so the scoreboard mirrors the full pipeline tail.
  logic unused_sb_wb;
  assign unused_sb_wb = ^sb_wb;

  assign active = !reset && !Mem_Busy;

  // A taken branch kills the ID instruction, so it wins over the stall; the
  // cycle after a load-use stall sees a bubble in EX and must not re-stall.
  assign load_use = active && !EX_Branch_EN && (state != ST_LOAD_STALL)
                 && sb_ex.mem_read
                 && (src_hits(sb_ex, ID_rs) || src_hits(sb_ex, ID_rt));

  assign branch_flush = active && EX_Branch_EN;
  assign jump_flush   = active && !EX_Branch_EN && !load_use && ID_Jump;
  assign bubble       = branch_flush || load_use;

  assign Stall_IF_ID = load_use;
  assign Flush_ID_EX = bubble;
  assign Flush_IF_ID = branch_flush || jump_flush;
  assign Freeze      = !reset && Mem_Busy;

  hz_fwd_sel u_fwd_a (
    .src       (ID_rs),
    .ex_entry  (sb_ex),
    .mem_entry (sb_mem),
    .fwd       (fwd_a_next)
  );

  hz_fwd_sel u_fwd_b (
    .src       (ID_rt),
    .ex_entry  (sb_ex),
    .mem_entry (sb_mem),
    .fwd       (fwd_b_next)
  );

  // NOTE: all state below uses non-blocking assignments so every register
  // samples the pre-edge values of the others, like real flip-flops.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_RUN;
      sb_ex     <= SB_BUBBLE;
      sb_mem    <= SB_BUBBLE;
      sb_wb     <= SB_BUBBLE;
      ForwardA  <= FWD_REG;
      ForwardB  <= FWD_REG;
      Stall_Cnt <= '0;
      Flush_Cnt <= '0;
    end else if (Mem_Busy) begin
      state <= ST_FROZEN;
      if (Stall_Cnt != CNT_MAX) Stall_Cnt <= Stall_Cnt + CNT_W'(1);
    end else begin
      sb_wb  <= sb_mem;
      sb_mem <= sb_ex;
      if (bubble) begin
        sb_ex    <= SB_BUBBLE;
        ForwardA <= FWD_REG;
        ForwardB <= FWD_REG;
      end else begin
        sb_ex    <= '{dest: ID_Dest, reg_write: ID_RegWrite, mem_read: ID_MemRead};
        ForwardA <= fwd_a_next;
        ForwardB <= fwd_b_next;
      end

      if (branch_flush)  state <= ST_FLUSH;
      else if (load_use) state <= ST_LOAD_STALL;
      else               state <= ST_RUN;

      if (load_use && Stall_Cnt != CNT_MAX) Stall_Cnt <= Stall_Cnt + CNT_W'(1);
      if (Flush_IF_ID && Flush_Cnt != CNT_MAX) Flush_Cnt <= Flush_Cnt + CNT_W'(1);
    end
  end

endmodule
